// File: rtl/leiwand_rv32_wb_interconnect_pkg.sv
// Shared types for the Wishbone interconnect: FSM encoding and the watchdog counter.
package leiwand_rv32_wb_interconnect_pkg;

  localparam int TMO_W = 16;

  typedef enum logic [1:0] {
    WB_IC_IDLE     = 2'd0,
    WB_IC_WAIT_ACK = 2'd1,
    WB_IC_ERR      = 2'd2
  } wb_ic_state_e;

  // Saturating increment so a long-running watchdog never wraps back to zero.
  function automatic logic [TMO_W-1:0] tmo_inc(input logic [TMO_W-1:0] t);
    return (&t) ? t : t + TMO_W'(1);
  endfunction

endpackage

// File: rtl/leiwand_rv32_wb_interconnect_addr_decode.sv
// Base/mask window decode: one-hot winner, its index and a miss flag.
module leiwand_rv32_wb_addr_decode #(
  parameter int MEM_WIDTH  = 32,
  parameter int NUM_SLAVES = 2,
  parameter int IDX_W      = 1,
  parameter logic [NUM_SLAVES*MEM_WIDTH-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*MEM_WIDTH-1:0] SLAVE_MASK = '0
) (
  input  logic [MEM_WIDTH-1:0]  addr,
  output logic [NUM_SLAVES-1:0] hit_oh,
  output logic [IDX_W-1:0]      idx,
  output logic                  miss
);

  logic [NUM_SLAVES-1:0] hit;

  for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_win
    assign hit[gi] = (addr & SLAVE_MASK[gi*MEM_WIDTH +: MEM_WIDTH])
                     == SLAVE_BASE[gi*MEM_WIDTH +: MEM_WIDTH];
  end

  // Overlapping windows resolve to the lowest index.
  assign hit_oh = hit & (~hit + NUM_SLAVES'(1));
  assign miss   = ~|hit;

  always_comb begin
    idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--)
      if (hit[i]) idx = IDX_W'(i);
  end

endmodule

// File: rtl/leiwand_rv32_wb_interconnect.sv
// Single-master, N-slave Wishbone interconnect with one outstanding access,
// ack watchdog and one-cycle error termination for unmapped or hung accesses.
module leiwand_rv32_wb_interconnect
  import leiwand_rv32_wb_interconnect_pkg::*;
#(
  parameter int MEM_WIDTH  = 32,
  parameter int NUM_SLAVES = 2,
  parameter logic [NUM_SLAVES*MEM_WIDTH-1:0] SLAVE_BASE = {32'h20400000, 32'h00000000},
  parameter logic [NUM_SLAVES*MEM_WIDTH-1:0] SLAVE_MASK = {32'hFFC00000, 32'hFFC00000},
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic [MEM_WIDTH-1:0]            wb_addr,
  input  logic [MEM_WIDTH-1:0]            wb_data_out,
  input  logic                            wb_we,
  input  logic                            wb_cyc,
  input  logic                            wb_stb,
  input  logic [2:0]                      data_write_size,
  output logic                            wb_ack,
  output logic                            wb_err,
  output logic                            wb_stall,
  output logic [MEM_WIDTH-1:0]            wb_data_in,
  output logic [NUM_SLAVES-1:0]           s_stb,
  input  logic [NUM_SLAVES-1:0]           s_ack,
  input  logic [NUM_SLAVES-1:0]           s_stall,
  input  logic [NUM_SLAVES*MEM_WIDTH-1:0] s_data,
  output logic [MEM_WIDTH-1:0]            err_addr
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  wb_ic_state_e                         state;
  logic [IDX_W-1:0]                     sel;
  logic [TMO_W-1:0]                     tmo;
  logic [NUM_SLAVES-1:0]                hit_oh;
  logic [IDX_W-1:0]                     dec_idx;
  logic                                 miss;
  logic                                 map_req;
  logic                                 accept;
  logic [NUM_SLAVES-1:0][MEM_WIDTH-1:0] s_data_a;
  logic                                 unused_ok;

  // Broadcast-only master signals; slaves pick them up directly.
  assign unused_ok = ^{wb_data_out, wb_we, data_write_size};
  assign s_data_a  = s_data;

  leiwand_rv32_wb_addr_decode #(
    .MEM_WIDTH (MEM_WIDTH),
    .NUM_SLAVES(NUM_SLAVES),
    .IDX_W     (IDX_W),
    .SLAVE_BASE(SLAVE_BASE),
    .SLAVE_MASK(SLAVE_MASK)
  ) u_dec (
    .addr  (wb_addr),
    .hit_oh(hit_oh),
    .idx   (dec_idx),
    .miss  (miss)
  );

  assign map_req = RST && (state == WB_IC_IDLE) && wb_cyc && wb_stb && !miss;
  assign accept  = map_req && !s_stall[dec_idx];
  assign s_stb   = map_req ? hit_oh : '0;

  always_comb begin
    wb_stall   = 1'b0;
    wb_ack     = 1'b0;
    wb_err     = 1'b0;
    wb_data_in = '0;
    case (state)
      WB_IC_IDLE: begin
        if (!miss) wb_data_in = s_data_a[dec_idx];
        if (map_req) wb_stall = s_stall[dec_idx];
        wb_ack = accept && s_ack[dec_idx];
      end
      WB_IC_WAIT_ACK: begin
        wb_stall   = 1'b1;
        wb_ack     = RST && wb_cyc && s_ack[sel];
        wb_data_in = s_data_a[sel];
      end
      WB_IC_ERR: begin
        wb_stall = 1'b1;
        wb_err   = RST && wb_cyc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state    <= WB_IC_IDLE;
      sel      <= '0;
      tmo      <= '0;
      err_addr <= '0;
    end else begin
      case (state)
        WB_IC_IDLE: begin
          if (wb_cyc && wb_stb) begin
            if (miss) begin
              err_addr <= wb_addr;
              state    <= WB_IC_ERR;
            end else if (!s_stall[dec_idx]) begin
              sel <= dec_idx;
              if (!s_ack[dec_idx]) begin
                state <= WB_IC_WAIT_ACK;
                tmo   <= '0;
              end
            end
          end
        end
        WB_IC_WAIT_ACK: begin
          // An ack on the final watchdog cycle still completes normally.
          if (!wb_cyc || s_ack[sel]) begin
            state <= WB_IC_IDLE;
          end else if (tmo == TMO_LAST) begin
            err_addr <= wb_addr;
            state    <= WB_IC_ERR;
          end else begin
            tmo <= tmo_inc(tmo);
          end
        end
        WB_IC_ERR: state <= WB_IC_IDLE;
        default:   state <= WB_IC_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_leiwand_rv32_wb_interconnect.sv
// Directed bench: default map, a short-watchdog instance and a fully overlapping map.
module tb_leiwand_rv32_wb_interconnect;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] wb_addr, wb_data_out;
  logic        wb_we, wb_cyc, wb_stb;
  logic [2:0]  data_write_size;
  logic [1:0]  s_ack, s_stall;
  logic [63:0] s_data;

  logic        ack_d, err_d, stall_d, ack_t, err_t, stall_t, ack_o, err_o, stall_o;
  logic [31:0] din_d, din_t, din_o, ea_d, ea_t, ea_o;
  logic [1:0]  stb_d, stb_t, stb_o;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  leiwand_rv32_wb_interconnect dut (
    .CLK(clk), .RST(rst), .wb_addr(wb_addr), .wb_data_out(wb_data_out), .wb_we(wb_we),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .data_write_size(data_write_size),
    .wb_ack(ack_d), .wb_err(err_d), .wb_stall(stall_d), .wb_data_in(din_d),
    .s_stb(stb_d), .s_ack(s_ack), .s_stall(s_stall), .s_data(s_data), .err_addr(ea_d)
  );

  leiwand_rv32_wb_interconnect #(.TIMEOUT_CYCLES(4)) dut_t (
    .CLK(clk), .RST(rst), .wb_addr(wb_addr), .wb_data_out(wb_data_out), .wb_we(wb_we),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .data_write_size(data_write_size),
    .wb_ack(ack_t), .wb_err(err_t), .wb_stall(stall_t), .wb_data_in(din_t),
    .s_stb(stb_t), .s_ack(s_ack), .s_stall(s_stall), .s_data(s_data), .err_addr(ea_t)
  );

  leiwand_rv32_wb_interconnect #(.SLAVE_BASE(64'h0), .SLAVE_MASK(64'h0)) dut_o (
    .CLK(clk), .RST(rst), .wb_addr(wb_addr), .wb_data_out(wb_data_out), .wb_we(wb_we),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .data_write_size(data_write_size),
    .wb_ack(ack_o), .wb_err(err_o), .wb_stall(stall_o), .wb_data_in(din_o),
    .s_stb(stb_o), .s_ack(s_ack), .s_stall(s_stall), .s_data(s_data), .err_addr(ea_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_bus();
    wb_cyc = 0; wb_stb = 0; s_ack = 0; s_stall = 0;
  endtask

  task automatic do_reset();
    idle_bus();
    rst = 0;
    tick();
    tick();
    rst = 1;
  endtask

  initial begin
    rst = 0; wb_addr = 0; wb_data_out = 32'h0BAD_F00D; wb_we = 0; data_write_size = 3'd4;
    s_data = {32'h5555_5555, 32'h1111_1111};
    idle_bus();

    // Reset state
    do_reset();
    settle();
    chk("rst_ack",   32'(ack_d),   0);
    chk("rst_err",   32'(err_d),   0);
    chk("rst_stb",   32'(stb_d),   0);
    chk("rst_stall", 32'(stall_d), 0);
    chk("rst_eaddr", ea_d,         0);

    // Read from slave1, ack one cycle later
    wb_cyc = 1; wb_stb = 1; wb_addr = 32'h2040_0004;
    settle();
    chk("rd_stb",   32'(stb_d),   32'h2);
    chk("rd_stall", 32'(stall_d), 0);
    chk("rd_ack0",  32'(ack_d),   0);
    tick();
    wb_stb = 0; s_ack = 2'b10; s_data = {32'hDEAD_BEEF, 32'h1111_1111};
    settle();
    chk("rd_stb_off", 32'(stb_d), 0);
    chk("rd_ack",     32'(ack_d), 1);
    chk("rd_data",    din_d,      32'hDEAD_BEEF);
    tick();
    s_ack = 0;
    settle();
    chk("rd_ack_done", 32'(ack_d), 0);

    // Slave0 stalls three cycles
    do_reset();
    wb_cyc = 1; wb_stb = 1; wb_addr = 32'h0000_0010; s_stall = 2'b01;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("stl_stall", 32'(stall_d), 1);
      chk("stl_stb",   32'(stb_d),   32'h1);
      tick();
    end
    s_stall = 0;
    settle();
    chk("stl_accept", 32'(stall_d), 0);
    chk("stl_stb4",   32'(stb_d),   32'h1);
    chk("stl_noack",  32'(ack_d),   0);
    tick();
    wb_stb = 0; s_ack = 2'b01; s_data = {32'h5555_5555, 32'hCAFE_F00D};
    settle();
    chk("stl_ack",  32'(ack_d), 1);
    chk("stl_data", din_d,      32'hCAFE_F00D);
    chk("stl_stb0", 32'(stb_d), 0);
    tick();
    idle_bus();

    // Unmapped access
    do_reset();
    wb_cyc = 1; wb_stb = 1; wb_addr = 32'h8000_0000;
    settle();
    chk("um_stall", 32'(stall_d), 0);
    chk("um_stb",   32'(stb_d),   0);
    chk("um_data",  din_d,        0);
    chk("um_err0",  32'(err_d),   0);
    tick();
    wb_stb = 0;
    settle();
    chk("um_err",   32'(err_d),   1);
    chk("um_ack",   32'(ack_d),   0);
    chk("um_eaddr", ea_d,         32'h8000_0000);
    tick();
    settle();
    chk("um_err_done", 32'(err_d), 0);
    chk("um_ack_done", 32'(ack_d), 0);

    // Timeout with TIMEOUT_CYCLES=4
    do_reset();
    wb_cyc = 1; wb_stb = 1; wb_addr = 32'h2040_0000;
    settle();
    chk("to_stb", 32'(stb_t), 32'h2);
    tick();
    wb_stb = 0;
    for (int k = 1; k <= 4; k++) begin
      settle();
      chk("to_wait_err",   32'(err_t),   0);
      chk("to_wait_stall", 32'(stall_t), 1);
      tick();
    end
    s_ack = 2'b10;
    settle();
    chk("to_err",      32'(err_t), 1);
    chk("to_late_ack", 32'(ack_t), 0);
    chk("to_eaddr",    ea_t,       32'h2040_0000);
    tick();
    s_ack = 0;
    settle();
    chk("to_err_done", 32'(err_t), 0);
    wb_stb = 1; wb_addr = 32'h2040_0008; s_ack = 2'b10; s_data = {32'h1234_5678, 32'h0};
    settle();
    chk("to_next_ack",  32'(ack_t), 1);
    chk("to_next_data", din_t,      32'h1234_5678);
    tick();
    idle_bus();

    // Ack arriving on the final watchdog cycle beats the timeout
    do_reset();
    wb_cyc = 1; wb_stb = 1; wb_addr = 32'h2040_0000;
    tick();
    wb_stb = 0;
    tick(); tick(); tick();
    s_ack = 2'b10;
    settle();
    chk("race_ack", 32'(ack_t), 1);
    chk("race_err", 32'(err_t), 0);
    tick();
    s_ack = 0;
    settle();
    chk("race_err_after", 32'(err_t), 0);

    // Drop wb_cyc while waiting
    do_reset();
    wb_cyc = 1; wb_stb = 1; wb_addr = 32'h2040_0004;
    tick();
    wb_cyc = 0; wb_stb = 0;
    settle();
    chk("cyc_ack", 32'(ack_d), 0);
    tick();
    wb_cyc = 1; s_ack = 2'b10;
    settle();
    chk("cyc_idle_stall", 32'(stall_d), 0);
    chk("cyc_stray_ack",  32'(ack_d),   0);
    chk("cyc_err",        32'(err_d),   0);
    s_ack = 0;

    // Reset mid-transaction, and err_addr cleared by reset
    do_reset();
    wb_cyc = 1; wb_stb = 1; wb_addr = 32'h8000_0000;
    tick();
    wb_addr = 32'h2040_0004;
    tick();
    tick();
    wb_stb = 0;
    rst = 0;
    tick();
    rst = 1; s_ack = 2'b10;
    settle();
    chk("mid_rst_stall", 32'(stall_d), 0);
    chk("mid_rst_ack",   32'(ack_d),   0);
    chk("mid_rst_err",   32'(err_d),   0);
    chk("mid_rst_eaddr", ea_d,         0);
    idle_bus();

    // Overlapping windows: slave0 wins, slave1 ack ignored
    do_reset();
    wb_cyc = 1; wb_stb = 1; wb_addr = 32'h2040_0004;
    settle();
    chk("ov_stb", 32'(stb_o), 32'h1);
    tick();
    wb_stb = 0; s_ack = 2'b10;
    settle();
    chk("ov_ign_ack", 32'(ack_o), 0);
    tick();
    s_ack = 2'b01; s_data = {32'h5A5A_5A5A, 32'hA5A5_A5A5};
    settle();
    chk("ov_ack",  32'(ack_o), 1);
    chk("ov_data", din_o,      32'hA5A5_A5A5);
    tick();
    idle_bus();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/leiwand_rv32_wb_interconnect.md
# leiwand_rv32_wb_interconnect

Parametrised Wishbone single-master, N-slave interconnect that sits between `leiwand_rv32_core` and the SoC's memories and peripherals, replacing the hard-wired single-bit address decode in the SoC top. It decodes each request against per-slave base/mask windows and routes strobe, stall, ack and read data. It tracks one outstanding transaction with a watchdog, and terminates unmapped or hung accesses with a one-cycle error pulse so the core never deadlocks.

## Interface
Parameters:
- `MEM_WIDTH`, 32: address and data width.
- `NUM_SLAVES`, 2: number of slave ports, 1..8.
- `SLAVE_BASE`, {32'h20400000, 32'h00000000}: packed `NUM_SLAVES*MEM_WIDTH` bases. Slice i is the base for slave i.
- `SLAVE_MASK`, {32'hFFC00000, 32'hFFC00000}: packed masks. Slave i hits when `(wb_addr & mask_i) == base_i`.
- `TIMEOUT_CYCLES`, 255: maximum cycles to wait for an ack, 1..65535.

Ports:
- `CLK` in 1: system clock.
- `RST` in 1: synchronous reset, active-low.
- `wb_addr` in MEM_WIDTH: master address. Broadcast to all slaves.
- `wb_data_out` in MEM_WIDTH: master write data. Broadcast.
- `wb_we`, `wb_cyc` in 1: master control. Broadcast.
- `wb_stb` in 1: master strobe.
- `data_write_size` in 3: byte count (1/2/4). Broadcast.
- `wb_ack` out 1: ack to master.
- `wb_err` out 1: error termination to master.
- `wb_stall` out 1: stall to master.
- `wb_data_in` out MEM_WIDTH: read data to master.
- `s_stb` out NUM_SLAVES: per-slave strobe.
- `s_ack` in NUM_SLAVES: per-slave ack.
- `s_stall` in NUM_SLAVES: per-slave stall.
- `s_data` in NUM_SLAVES*MEM_WIDTH: packed per-slave read data.
- `err_addr` out MEM_WIDTH: address of the most recent errored access.

## Operation
- Decode: a hit vector is computed from `wb_addr`. If windows overlap, the lowest index wins. No hit means unmapped.
- FSM states are IDLE, WAIT_ACK and ERR.
- IDLE, with `wb_cyc & wb_stb` and a hit on slave i:
  - `s_stb[i]=1`; `wb_stall=s_stall[i]`.
  - If not stalled, the request is accepted and `sel<=i`.
  - If `s_ack[i]` arrives in the same cycle, it passes through and the FSM stays in IDLE.
  - Otherwise the FSM goes to WAIT_ACK and `tmo<=0`.
- IDLE, with an unmapped request: `wb_stall=0` (accepted), `err_addr<=wb_addr`, go to ERR.
- WAIT_ACK:
  - `wb_stall=1` and all `s_stb=0`.
  - `wb_ack=s_ack[sel]` and `wb_data_in=s_data[sel]`.
  - On ack, go to IDLE.
  - Otherwise `tmo` increments. When `tmo==TIMEOUT_CYCLES-1` with no ack: `err_addr<=wb_addr`, go to ERR.
- ERR: `wb_err=1` for exactly one cycle, `wb_stall=1`, go to IDLE. Any late `s_ack` is ignored.
- `wb_cyc` low in any state: return to IDLE next cycle with no ack and no err. All `s_stb` are gated by `wb_cyc`.
- Acks from non-selected slaves are always ignored. `wb_ack` and `wb_err` are never high together.
- `wb_data_in` is `s_data[sel]` in WAIT_ACK, the decoded slave's data in IDLE, and 0 otherwise.

## Timing
- Reset (`RST=0` at a CLK edge):
  - state=IDLE, `sel=0`, `tmo=0`, `err_addr=0`.
  - Outputs `wb_ack=0`, `wb_err=0`, `s_stb=0`, `wb_stall=0`.
  - Reset mid-transaction drops it silently.
- Strobe, stall and ack paths are combinational: zero added latency.
- Unmapped access: `wb_err` is high exactly 1 cycle after the accept edge.
- Timeout: `wb_err` is high `TIMEOUT_CYCLES+1` cycles after the accept edge.
- `tmo` is 16 bits and saturates, so it never wraps.
- An ack on the same edge the timeout fires wins: `wb_ack=1`, no ERR.
- A new request is accepted only in IDLE, so at most one transaction is outstanding.

## Structure
- Add state encodings (`WB_IC_IDLE`, `WB_IC_WAIT_ACK`, `WB_IC_ERR`) to `leiwand_rv32_constants.v`.
- Sub-module `leiwand_rv32_wb_addr_decode`: combinational base/mask compare. Outputs a one-hot hit, a priority index and a `miss` flag.
- The top module holds the FSM, `tmo`, `sel`, `err_addr` and the muxes.

## Test plan
- Defaults; read `0x20400004`, slave1 acks 1 cycle later with `0xDEADBEEF` -> `s_stb=2'b10` for 1 cycle; `wb_ack=1` and `wb_data_in=0xDEADBEEF` on the next cycle.
- Slave0 holds `s_stall` for 3 cycles -> `wb_stall=1` for those cycles; accept on the 4th; ack routed; `s_stb[1]` stays 0 throughout.
- Access `0x80000000` (unmapped) -> `wb_err=1` for exactly one cycle, 1 cycle after the strobe; `err_addr=0x80000000`; `wb_ack` stays 0.
- `TIMEOUT_CYCLES=4`, slave never acks -> `wb_err` 5 cycles after accept; a later `s_ack` is ignored; the next access succeeds.
- Drop `wb_cyc` in WAIT_ACK, or pull `RST` low mid-transaction -> IDLE next cycle; no ack/err; outputs at reset values.
- Overlapping windows (both masks 0) -> slave0 selected; slave1 ack ignored.
